// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: sizing helper, counter init value
// and FSM state encoding.
package gshare_predictor_pkg;

   typedef enum logic {
      StInit = 1'b0,
      StRun  = 1'b1
   } bp_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // Weakly not-taken: MSB clear, all lower bits set.
   function automatic logic [31:0] wnt_value(input int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/sat_updn.sv
// Saturating up/down counter step: +1 when inc_i, -1 otherwise, holding at both rails.
module sat_updn #(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (inc_i) begin
         if (cnt_i != '1) cnt_o = cnt_i + WIDTH'(1);
      end else if (cnt_i != '0) begin
         cnt_o = cnt_i - WIDTH'(1);
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: counter table indexed by PC ^ speculative global history,
// initialised by a sweep after reset, with history repair on misprediction.
module gshare_predictor
   import gshare_predictor_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned LINES     = 64,
   parameter int unsigned HIST_BITS = 6,
   parameter int unsigned CTR_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PC_WIDTH-1:0]  pc_guess,
   input  logic                 is_br_guess,
   input  logic                 stall_guess,
   output logic                 br_pred_taken,
   output logic [HIST_BITS-1:0] ghr_guess,
   input  logic [PC_WIDTH-1:0]  pc_check,
   input  logic                 is_br_check,
   input  logic                 br_taken_check,
   input  logic                 pred_check,
   input  logic [HIST_BITS-1:0] ghr_check,
   output logic                 br_mispredict,
   output logic                 ready
);

   localparam int unsigned IDX = clog2(LINES);
   localparam logic [CTR_BITS-1:0] Wnt = CTR_BITS'(wnt_value(CTR_BITS));

   bp_state_e            state_q, state_d;
   logic [IDX-1:0]       ptr_q, ptr_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic                 ready_q, ready_d;

   logic [CTR_BITS-1:0]  table_q [LINES];
   logic [IDX-1:0]       idx_g, idx_c;
   logic [CTR_BITS-1:0]  ctr_g, ctr_c, ctr_upd;

   assign idx_g = pc_guess[IDX+1:2] ^ IDX'(ghr_q);
   assign idx_c = pc_check[IDX+1:2] ^ IDX'(ghr_check);
   assign ctr_g = table_q[idx_g];
   assign ctr_c = table_q[idx_c];

   assign br_pred_taken = ready_q & is_br_guess & ctr_g[CTR_BITS-1];
   assign br_mispredict = is_br_check & (br_taken_check != pred_check);
   assign ghr_guess     = ghr_q;
   assign ready         = ready_q;

   sat_updn #(
      .WIDTH (CTR_BITS)
   ) u_sat_updn (
      .cnt_i (ctr_c),
      .inc_i (br_taken_check),
      .cnt_o (ctr_upd)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ghr_d   = ghr_q;
      ready_d = ready_q;
      unique case (state_q)
         StInit: begin
            ptr_d = ptr_q + IDX'(1);
            if (ptr_q == IDX'(LINES - 1)) begin
               state_d = StRun;
               ready_d = 1'b1;
            end
         end
         StRun: begin
            // Repair wins over the speculative shift issued in the same cycle.
            if (br_mispredict) begin
               ghr_d = HIST_BITS'({ghr_check, br_taken_check});
            end else if (is_br_guess && !stall_guess) begin
               ghr_d = HIST_BITS'({ghr_q, br_pred_taken});
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StInit;
         ptr_q   <= '0;
         ghr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ghr_q   <= ghr_d;
         ready_q <= ready_d;
      end
   end

   // No per-entry reset: the init sweep provides the known starting contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state_q == StInit) begin
            table_q[ptr_q] <= Wnt;
         end else if (is_br_check) begin
            table_q[idx_c] <= ctr_upd;
         end
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_guess[PC_WIDTH-1:IDX+2], pc_guess[1:0],
                             pc_check[PC_WIDTH-1:IDX+2], pc_check[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor at LINES=64, HIST_BITS=6, CTR_BITS=2.
module tb_gshare_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_guess;
   logic        is_br_guess;
   logic        stall_guess;
   logic        br_pred_taken;
   logic [5:0]  ghr_guess;
   logic [31:0] pc_check;
   logic        is_br_check;
   logic        br_taken_check;
   logic        pred_check;
   logic [5:0]  ghr_check;
   logic        br_mispredict;
   logic        ready;

   always #5 clk = ~clk;

   gshare_predictor dut (
      .clk            (clk),
      .reset          (reset),
      .pc_guess       (pc_guess),
      .is_br_guess    (is_br_guess),
      .stall_guess    (stall_guess),
      .br_pred_taken  (br_pred_taken),
      .ghr_guess      (ghr_guess),
      .pc_check       (pc_check),
      .is_br_check    (is_br_check),
      .br_taken_check (br_taken_check),
      .pred_check     (pred_check),
      .ghr_check      (ghr_check),
      .br_mispredict  (br_mispredict),
      .ready          (ready)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, obs, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with ready low after reset release; bounded so a stuck FSM still ends.
   task automatic sweep(input string tag);
      int unsigned n_low  = 0;
      int unsigned n_pred = 0;
      expect_val({tag, "_len"}, 32'd64);
      expect_val({tag, "_pred_during_init"}, 32'd0);
      expect_val({tag, "_ghr_after_init"}, 32'd0);
      for (int i = 0; i < 200; i++) begin
         #1;
         if (ready) break;
         n_low++;
         if (br_pred_taken) n_pred++;
         tick();
      end
      observe(n_low);
      observe(n_pred);
      observe(32'(ghr_guess));
   endtask

   task automatic train(input logic taken, input logic exp_pred, input int idx);
      pc_check       = 32'h100;
      ghr_check      = 6'd0;
      is_br_check    = 1'b1;
      br_taken_check = taken;
      pred_check     = taken;
      tick();
      is_br_check = 1'b0;
      pc_guess    = 32'h100;
      is_br_guess = 1'b1;
      stall_guess = 1'b1;
      expect_val($sformatf("train%0d_pred", idx), 32'(exp_pred));
      #1;
      observe(32'(br_pred_taken));
   endtask

   task automatic spec_step(input logic [31:0] pc, input logic exp_pred, input logic [5:0] exp_ghr,
                            input int idx);
      pc_guess    = pc;
      is_br_guess = 1'b1;
      stall_guess = 1'b0;
      expect_val($sformatf("spec%0d_pred", idx), 32'(exp_pred));
      expect_val($sformatf("spec%0d_ghr", idx), 32'(exp_ghr));
      #1;
      observe(32'(br_pred_taken));
      tick();
      observe(32'(ghr_guess));
   endtask

   localparam logic [8:0] TrainTaken = 9'b110000111;
   localparam logic [8:0] TrainPred  = 9'b100001111;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [8:0] tr_taken;
      logic [8:0] tr_pred;
      int unsigned n_high;
      tr_taken = TrainTaken;
      tr_pred  = TrainPred;

      reset          = 1'b0;
      pc_guess       = 32'h0;
      is_br_guess    = 1'b1;
      stall_guess    = 1'b0;
      // Mispredicting checks stay active through init; they must be dropped.
      pc_check       = 32'h0;
      ghr_check      = 6'd0;
      is_br_check    = 1'b1;
      br_taken_check = 1'b1;
      pred_check     = 1'b0;
      repeat (3) tick();

      expect_val("rst_ready", 32'd0);
      expect_val("rst_pred", 32'd0);
      expect_val("rst_ghr", 32'd0);
      expect_val("rst_mispredict", 32'd1);
      observe(32'(ready));
      observe(32'(br_pred_taken));
      observe(32'(ghr_guess));
      observe(32'(br_mispredict));
      pred_check = 1'b1;
      expect_val("rst_mispredict_match", 32'd0);
      #1;
      observe(32'(br_mispredict));
      pred_check = 1'b0;

      reset = 1'b1;
      sweep("sweep1");
      is_br_check = 1'b0;
      is_br_guess = 1'b0;

      // Reset mid-sweep must restart the full sweep.
      reset = 1'b0;
      tick();
      reset       = 1'b1;
      is_br_guess = 1'b1;
      is_br_check = 1'b1;
      repeat (30) tick();
      expect_val("midsweep_ready", 32'd0);
      observe(32'(ready));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      sweep("sweep2");
      is_br_check = 1'b0;
      is_br_guess = 1'b0;

      // Every entry should be weakly not-taken.
      tick();
      is_br_guess = 1'b1;
      stall_guess = 1'b1;
      n_high = 0;
      for (int i = 0; i < 64; i++) begin
         pc_guess = 32'(i * 4);
         #1;
         if (br_pred_taken) n_high++;
      end
      expect_val("scan_wnt_pred_high", 32'd0);
      observe(n_high);

      for (int i = 0; i < 9; i++) begin
         train(tr_taken[i], tr_pred[i], i);
      end
      expect_val("train_ghr_untouched", 32'd0);
      observe(32'(ghr_guess));

      spec_step(32'h100, 1'b1, 6'b000001, 0);
      spec_step(32'h100, 1'b0, 6'b000010, 1);
      spec_step(32'h108, 1'b1, 6'b000101, 2);

      stall_guess = 1'b1;
      tick();
      expect_val("stall_ghr_hold", 32'(6'b000101));
      observe(32'(ghr_guess));
      is_br_guess = 1'b0;
      stall_guess = 1'b0;
      tick();
      expect_val("noguess_ghr_hold", 32'(6'b000101));
      observe(32'(ghr_guess));

      // Repair and an unstalled guess in the same cycle.
      is_br_guess    = 1'b1;
      stall_guess    = 1'b0;
      pc_guess       = 32'h100;
      is_br_check    = 1'b1;
      pc_check       = 32'h100;
      ghr_check      = 6'b000011;
      br_taken_check = 1'b1;
      pred_check     = 1'b0;
      expect_val("repair_mispredict", 32'd1);
      expect_val("repair_ghr", 32'(6'b000111));
      #1;
      observe(32'(br_mispredict));
      tick();
      observe(32'(ghr_guess));

      is_br_guess = 1'b0;
      pc_check    = 32'h110;
      ghr_check   = 6'd0;
      tick();
      expect_val("repair2_ghr", 32'(6'b000001));
      observe(32'(ghr_guess));

      // Guess idx 0x41^1 and check idx 0x40^0 both map to entry 0 (currently 2'b10).
      is_br_guess    = 1'b1;
      stall_guess    = 1'b1;
      pc_guess       = 32'h104;
      is_br_check    = 1'b1;
      pc_check       = 32'h100;
      ghr_check      = 6'd0;
      br_taken_check = 1'b0;
      pred_check     = 1'b0;
      expect_val("alias_old_pred", 32'd1);
      expect_val("alias_no_mispredict", 32'd0);
      expect_val("alias_new_pred", 32'd0);
      expect_val("alias_ghr", 32'(6'b000001));
      #1;
      observe(32'(br_pred_taken));
      observe(32'(br_mispredict));
      tick();
      is_br_check = 1'b0;
      #1;
      observe(32'(br_pred_taken));
      observe(32'(ghr_guess));

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor of the 2-bit BHT predictor: a direct-mapped table of CTR_BITS saturating counters indexed by PC XOR global history (gshare).
- Holds a speculative global history register (GHR). The GHR is shifted at guess time and repaired on a misprediction at check time.
- A reset sweep FSM initialises every counter, so the table needs no per-entry reset.
- Sits beside IF (guess side) and the branch-resolve stage (check side) of the riscv_core.

Parameters:
- PC_WIDTH, 32, PC width in bits.
- LINES, 64, counter table entries; must be a power of 2 and at least 2. IDX = log2(LINES).
- HIST_BITS, 6, GHR length; legal range 1..IDX.
- CTR_BITS, 2, saturating counter width; must be at least 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled 0 on a rising clk edge resets the block.
- pc_guess  in  PC_WIDTH  PC of the instruction in IF.
- is_br_guess  in  1  the IF instruction is a conditional branch.
- stall_guess  in  1  IF is held; no GHR shift this cycle.
- br_pred_taken  out  1  prediction for pc_guess (combinational).
- ghr_guess  out  HIST_BITS  GHR value used for this prediction; the pipeline carries it to the check stage.
- pc_check  in  PC_WIDTH  PC of the resolving branch.
- is_br_check  in  1  a branch resolves this cycle.
- br_taken_check  in  1  actual branch outcome.
- pred_check  in  1  prediction that was made for this branch (carried down the pipeline).
- ghr_check  in  HIST_BITS  ghr_guess snapshot carried with this branch.
- br_mispredict  out  1  is_br_check && (br_taken_check != pred_check), combinational.
- ready  out  1  high once initialisation is complete.

Behaviour:
- Index rules:
  - idx_g = pc_guess[IDX+1:2] XOR zero-extend(ghr).
  - idx_c = pc_check[IDX+1:2] XOR zero-extend(ghr_check).
  - History XORs into the low bits of the index.
- FSM states: INIT, RUN.
- Reset (reset=0 at edge): state <= INIT, sweep pointer <= 0, ghr <= 0. Reset in any state, including mid-sweep, restarts the sweep from 0.
- INIT:
  - Each cycle, table[ptr] <= WNT and ptr increments. WNT (weakly not-taken) is the counter with MSB 0 and all other bits 1; for CTR_BITS=2 this is 2'b01.
  - After the write at ptr = LINES-1, go to RUN. The sweep takes exactly LINES cycles.
  - Outputs during INIT: ready=0, br_pred_taken=0.
  - Checks are dropped: no table write, no GHR change. br_mispredict is still computed.
- RUN: ready=1.
- Prediction: br_pred_taken = ready && is_br_guess && table[idx_g][CTR_BITS-1]. Table read is asynchronous. ghr_guess = ghr.
- Counter update (RUN && is_br_check):
  - Saturating +1 if taken, -1 if not taken.
  - Holds at all-ones and at zero.
  - Written to table[idx_c] at the edge.
- Same-cycle read/write to the same entry: the guess sees the pre-update value; there is no bypass.
- GHR update, in priority order:
  1. RUN && br_mispredict: ghr <= {ghr_check[HIST_BITS-2:0], br_taken_check}. This is repair; it overrides any guess-side shift that cycle.
  2. Otherwise, RUN && is_br_guess && !stall_guess: ghr <= {ghr[HIST_BITS-2:0], br_pred_taken}.
  3. Otherwise ghr holds.
  - For HIST_BITS=1 the shifted value is the new bit alone.
- A correct prediction at check leaves the GHR untouched; its speculative shift was already right.
- Reset values of outputs: ready=0, br_pred_taken=0, ghr_guess=0. br_mispredict follows its inputs.

Decomposition:
- Shared header bp_defs.vh holds:
  - the clog2 function;
  - the WNT init-value expression;
  - the state encodings INIT=1'b0, RUN=1'b1.
- One sub-module: reuse the existing sat_updn (WIDTH=CTR_BITS) for the counter update.
- Table array, index XOR, GHR and FSM stay in gshare_predictor.

Test Plan (LINES=64, HIST_BITS=6, CTR_BITS=2 unless noted):
- Init sweep: release reset, is_br_guess=1 throughout. ready=0 and br_pred_taken=0 for exactly 64 cycles; ready=1 on cycle 65. Every entry then reads 2'b01.
- Reset mid-sweep: assert reset at cycle 30 of INIT, release. A full 64-cycle sweep restarts and ready stays 0 until it completes.
- Training: pc=0x100, ghr_check=0, three taken checks. Counter goes 01->10->11->11 (saturates). A later guess at pc=0x100 with ghr=0 predicts 1.
- Speculative history: guess branches predicted 1,0,1 with stall_guess=0 from ghr=0 -> ghr=6'b000101. A stalled cycle with is_br_guess=1 leaves ghr unchanged.
- Repair priority: in one cycle, br_mispredict (ghr_check=6'b000011, taken=1) and an unstalled guess. ghr=6'b000111 next cycle; the guess-side shift is discarded.
- Aliasing and no bypass: pc_guess=0x104 with ghr=6'b000001, and pc_check=0x100 with ghr_check=0, both map to idx 0. Guess and check in the same cycle: the guess returns the old MSB; the updated counter is visible next cycle.
